// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and I2C-master signal bundle for i2c_txn_arbiter
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 7
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_r_w;
  logic [NUM_REQ*ADDR_WD-1:0] req_addr;
  logic [NUM_REQ*DATA_WD-1:0] req_wdata;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         resp_valid;
  logic                       resp_err;
  logic [DATA_WD-1:0]         resp_rdata;
  logic                       m_en;
  logic                       m_r_w;
  logic [ADDR_WD-1:0]         m_addr;
  logic [DATA_WD-1:0]         m_wdata;
  logic [DATA_WD-1:0]         m_rdata;
  logic                       m_done;
  logic                       busy;

  modport master (
    input  req_valid, req_r_w, req_addr, req_wdata, m_rdata, m_done,
    output req_ready, resp_valid, resp_err, resp_rdata,
           m_en, m_r_w, m_addr, m_wdata, busy
  );

  modport slave (
    output req_valid, req_r_w, req_addr, req_wdata, m_rdata, m_done,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           m_en, m_r_w, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sharing of one I2C master among NUM_REQ clients
module i2c_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 7,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  i2c_txn_arbiter_if.master  bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e              state_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       last_grant_q;
  logic [TW-1:0]       timer_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic                resp_err_q;
  logic [DATA_WD-1:0]  resp_rdata_q;
  logic                m_en_q;
  logic                m_r_w_q;
  logic [ADDR_WD-1:0]  m_addr_q;
  logic [DATA_WD-1:0]  m_wdata_q;
  logic                busy_q;

  logic [GW-1:0]       grant_d;
  logic                grant_vld_d;
  int                  g_idx;
  logic [NUM_REQ-1:0]  req_oh_d;
  logic [NUM_REQ-1:0]  resp_oh;
  logic                r_w_d;
  logic [ADDR_WD-1:0]  addr_d;
  logic [DATA_WD-1:0]  wdata_d;

  // Scan from last_grant+1 upward; walking j downward lets the nearest requester win.
  always_comb begin
    grant_d     = last_grant_q;
    grant_vld_d = 1'b0;
    g_idx       = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      g_idx = int'(last_grant_q) + 1 + j;
      if (g_idx >= NUM_REQ) g_idx = g_idx - NUM_REQ;
      if (bus.req_valid[GW'(g_idx)]) begin
        grant_vld_d = 1'b1;
        grant_d     = GW'(g_idx);
      end
    end
  end

  always_comb begin
    req_oh_d = '0;
    resp_oh  = '0;
    r_w_d    = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_d) begin
        req_oh_d[i] = 1'b1;
        r_w_d       = bus.req_r_w[i];
        addr_d      = bus.req_addr[i*ADDR_WD +: ADDR_WD];
        wdata_d     = bus.req_wdata[i*DATA_WD +: DATA_WD];
      end
      if (GW'(i) == grant_q) resp_oh[i] = 1'b1;
    end
  end

  // Outputs are set on entry to the state in which they are meant to be seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      timer_q      <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      m_en_q       <= 1'b0;
      m_r_w_q      <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      m_en_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            grant_q     <= grant_d;
            m_r_w_q     <= r_w_d;
            m_addr_q    <= addr_d;
            m_wdata_q   <= wdata_d;
            req_ready_q <= req_oh_d;
            m_en_q      <= 1'b1;
            timer_q     <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (bus.m_done) begin
            resp_rdata_q <= m_r_w_q ? bus.m_rdata : '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= resp_oh;
            state_q      <= ST_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= resp_oh;
            state_q      <= ST_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP: begin
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.m_en       = m_en_q;
  assign bus.m_r_w      = m_r_w_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_wdata    = m_wdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed bench; dut_a uses TIMEOUT=255, dut_b uses TIMEOUT=8
module tb_i2c_txn_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_r_w;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  m_rdata;
  logic        m_done;
  logic        sel_b;

  int n_checks = 0;
  int n_errors = 0;
  int extra;
  bit ok;
  logic [3:0] oh;

  i2c_txn_arbiter_if #(.NUM_REQ(4), .DATA_WD(8), .ADDR_WD(7)) bus_a ();
  i2c_txn_arbiter_if #(.NUM_REQ(4), .DATA_WD(8), .ADDR_WD(7)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_r_w   = req_r_w;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.m_rdata   = m_rdata;
  assign bus_a.m_done    = m_done;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_r_w   = req_r_w;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.m_rdata   = m_rdata;
  assign bus_b.m_done    = m_done;

  i2c_txn_arbiter #(.NUM_REQ(4), .DATA_WD(8), .ADDR_WD(7), .TIMEOUT(255)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  i2c_txn_arbiter #(.NUM_REQ(4), .DATA_WD(8), .ADDR_WD(7), .TIMEOUT(8)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  logic [3:0] o_req_ready, o_resp_valid;
  logic       o_resp_err, o_m_en, o_m_r_w, o_busy;
  logic [7:0] o_resp_rdata, o_m_wdata;
  logic [6:0] o_m_addr;

  always_comb begin
    o_req_ready  = sel_b ? bus_b.req_ready  : bus_a.req_ready;
    o_resp_valid = sel_b ? bus_b.resp_valid : bus_a.resp_valid;
    o_resp_err   = sel_b ? bus_b.resp_err   : bus_a.resp_err;
    o_resp_rdata = sel_b ? bus_b.resp_rdata : bus_a.resp_rdata;
    o_m_en       = sel_b ? bus_b.m_en       : bus_a.m_en;
    o_m_r_w      = sel_b ? bus_b.m_r_w      : bus_a.m_r_w;
    o_m_addr     = sel_b ? bus_b.m_addr     : bus_a.m_addr;
    o_m_wdata    = sel_b ? bus_b.m_wdata    : bus_a.m_wdata;
    o_busy       = sel_b ? bus_b.busy       : bus_a.busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sel(input logic b);
    sel_b = b;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_men(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_m_en) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_r_w = '0; req_addr = '0; req_wdata = '0;
    m_rdata = '0; m_done = 1'b0; sel_b = 1'b0;
    step(2);
    rst = 1'b0;

    check_eq("rst_a_outs", 32'({o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata, o_m_en, o_m_r_w, o_m_addr}), 32'd0);
    check_eq("rst_a_wd_busy", 32'({o_m_wdata, o_busy}), 32'd0);
    set_sel(1'b1);
    check_eq("rst_b_outs", 32'({o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata, o_m_en, o_m_r_w, o_m_addr}), 32'd0);
    check_eq("rst_b_wd_busy", 32'({o_m_wdata, o_busy}), 32'd0);
    set_sel(1'b0);

    // single write from requester 2, done 10 cycles after m_en
    req_addr[14 +: 7] = 7'h50; req_wdata[16 +: 8] = 8'hA5; req_r_w[2] = 1'b0; req_valid = 4'b0100;
    step();
    check_eq("wr_ready", 32'(o_req_ready), 32'(4'b0100));
    check_eq("wr_men_busy", 32'({o_m_en, o_busy}), 32'(2'b11));
    check_eq("wr_latch", 32'({o_m_r_w, o_m_addr, o_m_wdata}), 32'({1'b0, 7'h50, 8'hA5}));
    req_valid = '0;
    extra = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (o_m_en || o_resp_valid != 4'b0) extra++;
    end
    step();
    m_done = 1'b1; m_rdata = 8'hFF;
    step();
    m_done = 1'b0;
    check_eq("wr_quiet_wait", 32'(extra), 32'd0);
    check_eq("wr_resp", 32'({o_resp_valid, o_resp_err, o_resp_rdata}), 32'({4'b0100, 1'b0, 8'h00}));
    step();
    check_eq("wr_idle", 32'({o_resp_valid, o_busy}), 32'd0);
    check_eq("wr_hold", 32'({o_m_addr, o_m_wdata}), 32'({7'h50, 8'hA5}));

    // read from requester 0
    req_r_w[0] = 1'b1; req_addr[0 +: 7] = 7'h1C; req_valid = 4'b0001;
    step();
    check_eq("rd_ready", 32'(o_req_ready), 32'(4'b0001));
    check_eq("rd_latch", 32'({o_m_en, o_m_r_w, o_m_addr}), 32'({1'b1, 1'b1, 7'h1C}));
    req_valid = '0;
    step();
    m_done = 1'b1; m_rdata = 8'h3C;
    step();
    m_done = 1'b0; m_rdata = 8'h00;
    check_eq("rd_resp", 32'({o_resp_valid, o_resp_err, o_resp_rdata}), 32'({4'b0001, 1'b0, 8'h3C}));
    step();

    // round-robin with all four held from reset
    req_r_w = '0;
    req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
    req_valid = 4'b1111;
    do_reset();
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      wait_men(20, ok);
      check_eq("rr_men_seen", 32'(ok), 32'd1);
      check_eq("rr_grant", 32'(o_req_ready), 32'(oh));
      check_eq("rr_addr", 32'(o_m_addr), 32'(7'h10 + 7'(k % 4)));
      for (int i = 0; i < 3; i++) begin
        step();
        if (o_m_en) extra++;
      end
      m_done = 1'b1;
      step();
      m_done = 1'b0;
      if (o_m_en) extra++;
      check_eq("rr_resp", 32'(o_resp_valid), 32'(oh));
    end
    check_eq("rr_single_men", 32'(extra), 32'd0);
    req_valid = '0;
    step(2);

    // timeout on requester 1 (TIMEOUT=8), requester 3 pending behind it
    set_sel(1'b1);
    do_reset();
    req_addr[7 +: 7] = 7'h22; req_addr[21 +: 7] = 7'h33; req_r_w[3] = 1'b1;
    m_rdata = 8'hEE; req_valid = 4'b1010;
    step();
    check_eq("to_ready", 32'(o_req_ready), 32'(4'b0010));
    check_eq("to_latch", 32'({o_m_en, o_m_addr}), 32'({1'b1, 7'h22}));
    req_valid = 4'b1000;
    step(8);
    check_eq("to_last_wait", 32'({o_resp_valid, o_busy}), 32'({4'b0000, 1'b1}));
    step();
    check_eq("to_resp", 32'({o_resp_valid, o_resp_err, o_resp_rdata}), 32'({4'b0010, 1'b1, 8'h00}));
    step(2);
    check_eq("to_next_grant", 32'({o_req_ready, o_m_en, o_m_r_w, o_m_addr}), 32'({4'b1000, 1'b1, 1'b1, 7'h33}));
    check_eq("to_err_hold", 32'(o_resp_err), 32'd1);
    req_valid = '0;

    // done coincides with the final timeout cycle
    step(8);
    m_done = 1'b1; m_rdata = 8'h5A;
    step();
    m_done = 1'b0;
    check_eq("col_resp", 32'({o_resp_valid, o_resp_err, o_resp_rdata}), 32'({4'b1000, 1'b0, 8'h5A}));

    // spurious done while idle
    step();
    m_done = 1'b1; m_rdata = 8'h77;
    step();
    m_done = 1'b0;
    check_eq("spur_idle", 32'({o_busy, o_m_en, o_resp_valid, o_req_ready}), 32'd0);
    check_eq("spur_rdata_hold", 32'(o_resp_rdata), 32'(8'h5A));
    step(2);
    check_eq("spur_still_idle", 32'({o_busy, o_resp_valid}), 32'd0);

    // reset during WAIT restores requester 0 priority
    set_sel(1'b0);
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    step();
    req_valid = 4'b1111;
    step();
    check_eq("mid_grant3", 32'(o_req_ready), 32'(4'b1000));
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_outs", 32'({o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata, o_m_en, o_m_r_w, o_m_addr}), 32'd0);
    check_eq("mid_rst_wd_busy", 32'({o_m_wdata, o_busy}), 32'd0);
    step();
    check_eq("mid_req0_wins", 32'({o_req_ready, o_m_en}), 32'({4'b0001, 1'b1}));
    req_valid = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C master controller among NUM_REQ independent requesters. The controller uses the en/r_w/addr/wdata → done/rdata interface.
- Arbitrates round-robin and latches the winning transaction. Pulses the master enable, waits for done with a timeout, then returns read data or an error to the granted requester.
- Sits between on-chip clients (config FSMs, sensor pollers) and the single I2C master that drives scl/sda.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WD, 8, I2C data byte width.
- ADDR_WD, 7, I2C slave address width.
- TIMEOUT, 255, maximum cycles spent in WAIT before aborting (≥2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester transaction request; held until req_ready.
- req_r_w  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*ADDR_WD  packed slave addresses; requester i at [i*ADDR_WD +: ADDR_WD].
- req_wdata  in  NUM_REQ*DATA_WD  packed write bytes; requester i at [i*DATA_WD +: DATA_WD].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = timeout.
- resp_rdata  out  DATA_WD  read byte; qualifies resp_valid.
- m_en  out  1  one-cycle start pulse to the I2C master.
- m_r_w  out  1  latched direction to the master.
- m_addr  out  ADDR_WD  latched address to the master.
- m_wdata  out  DATA_WD  latched write data to the master.
- m_rdata  in  DATA_WD  read data from the master; valid with m_done.
- m_done  in  1  master completion pulse.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0: req_ready, resp_valid, resp_err, resp_rdata, m_en, m_r_w, m_addr, m_wdata, busy.
  - Internal timer = 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
  - rst is sampled every cycle; asserting it in any state aborts immediately. No resp_valid is issued for the aborted transaction.
- All outputs are registered.
- IDLE:
  - If any req_valid, pick grant g = first asserted index scanning last_grant+1, last_grant+2, … (mod NUM_REQ).
  - Latch g, req_r_w[g], req_addr slice and req_wdata slice into m_r_w/m_addr/m_wdata.
  - Pulse req_ready[g] and go to ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE: m_en = 1 for exactly this cycle; clear timer; go to WAIT.
- WAIT:
  - m_en = 0.
  - If m_done: resp_rdata = m_r_w ? m_rdata : 0, resp_err = 0, go to RESP.
  - Else if timer == TIMEOUT-1: resp_rdata = 0, resp_err = 1, go to RESP.
  - Else timer += 1.
  - If m_done and the timeout condition occur in the same cycle, m_done wins (resp_err = 0).
- RESP: resp_valid[g] = 1 for this cycle; last_grant = g; go to IDLE.
- Hold rules:
  - m_r_w, m_addr and m_wdata hold the latched values from IDLE exit until the next grant.
  - resp_rdata and resp_err hold until the next RESP.
- Ignored inputs:
  - m_done is ignored in IDLE, ISSUE and RESP.
  - m_rdata is sampled only with m_done in WAIT.
- Requester contract: fields must stay stable while req_valid is high and before req_ready. A req_valid that deasserts before being granted is dropped without side effects.
- Throughput: a grant is at most one per transaction; minimum 4 cycles from grant to next grant (IDLE→ISSUE→WAIT→RESP→IDLE) when the master completes in 1 cycle.
- Latency: req_ready arrives 1 cycle after req_valid if the arbiter is IDLE. resp_valid arrives 1 cycle after the m_done sample.
- Fairness: a continuously requesting client waits for at most NUM_REQ-1 other transactions.

Test Plan:
- Single write: req_valid[2]=1, addr=7'h50, wdata=8'hA5, r_w=0; master returns m_done 10 cycles after m_en.
  - Expect req_ready[2] pulse, then a single m_en pulse with m_addr=50 and m_wdata=A5.
  - Expect resp_valid[2] 1 cycle after m_done, resp_err=0, resp_rdata=0.
- Read: req 0 r_w=1, addr=7'h1C; master asserts m_done with m_rdata=8'h3C.
  - Expect resp_valid[0], resp_rdata=3C, resp_err=0.
- Round-robin: all four req_valid held high from reset, each master transaction completing in 3 cycles.
  - Expect grants in order 0,1,2,3,0.
  - Expect exactly one m_en per grant and never two in flight.
- Timeout: TIMEOUT=8, m_done never asserted after grant to req 1.
  - Expect resp_valid[1] with resp_err=1 and resp_rdata=0, exactly 8 WAIT cycles after the m_en cycle.
  - Expect the next pending requester is then served.
- Collision and spurious done:
  - m_done on the final WAIT cycle (timer=TIMEOUT-1) → expect resp_err=0 with data captured.
  - m_done pulsed in IDLE → no state change, no resp_valid.
- Reset mid-transaction: assert rst for 1 cycle while in WAIT.
  - Next cycle: all outputs 0, busy=0, no resp_valid.
  - Requester 0 wins if all requesters are active.
